// File: rtl/execute_stage.sv
// Execute stage of the in-order RV32I integer pipeline.
//
// Owns the 32x32 integer register file, forwards operands from EX/MEM and
// writeback, evaluates the ALU on the decoded control code and registers the
// result into the EX/MEM pipeline register. A load immediately followed by a
// dependent instruction produces a one-cycle bubble and stalls decode/fetch.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   d_*                decoded instruction fields from the decode register stage
//   stall_in           downstream stall; EX/MEM holds
//   wb_en/addr/data    writeback port into the register file (also bypassed)
//   e_*                EX/MEM pipeline register outputs
//   stall_out          combinational; hold decode and fetch this cycle
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_imm,
    input  logic [4:0]  d_ctl,
    input  logic        d_src_imm,
    input  logic        d_src_pc,
    input  logic        d_read_reg1,
    input  logic        d_read_reg2,
    input  logic [4:0]  d_reg1_addr,
    input  logic [4:0]  d_reg2_addr,
    input  logic [4:0]  d_write_reg,
    input  logic        d_reg_write,
    input  logic        d_mem_read,
    input  logic        d_mem_write,
    input  logic [31:0] d_pc,
    input  logic        stall_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] e_result,
    output logic [31:0] e_store_data,
    output logic [4:0]  e_write_reg,
    output logic        e_reg_write,
    output logic        e_mem_read,
    output logic        e_mem_write,
    output logic        stall_out
);

    logic [31:0] rf_q [32];

    logic [31:0] result_q, result_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic [31:0] rs1_fwd, rs2_fwd;
    logic [31:0] op_a, op_b;
    logic [31:0] alu_res;
    logic        load_use;

    // Register file; entry 0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // EX/MEM is younger than WB, so it takes priority. Loads in EX/MEM have
    // no value yet; that case is covered by the load-use stall instead.
    function automatic logic [31:0] fwd(
        input logic [4:0]  addr,
        input logic [31:0] rf_val,
        input logic        ex_rw,
        input logic        ex_mr,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_res,
        input logic        w_en,
        input logic [4:0]  w_addr,
        input logic [31:0] w_data
    );
        logic [31:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (ex_rw && !ex_mr && (ex_rd == addr)) begin
            val = ex_res;
        end else if (w_en && (w_addr == addr)) begin
            val = w_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    always_comb begin
        rs1_fwd = fwd(d_reg1_addr, rf_q[d_reg1_addr], reg_write_q, mem_read_q, write_reg_q,
                      result_q, wb_en, wb_addr, wb_data);
        rs2_fwd = fwd(d_reg2_addr, rf_q[d_reg2_addr], reg_write_q, mem_read_q, write_reg_q,
                      result_q, wb_en, wb_addr, wb_data);
        op_a    = d_src_pc  ? d_pc  : rs1_fwd;
        op_b    = d_src_imm ? d_imm : rs2_fwd;
    end

    always_comb begin
        alu_res = '0;
        case (d_ctl)
            5'd0:    alu_res = op_a & op_b;
            5'd1:    alu_res = op_a | op_b;
            5'd2:    alu_res = op_a + op_b;
            5'd3:    alu_res = op_a ^ op_b;
            5'd4:    alu_res = op_a << op_b[4:0];
            5'd5:    alu_res = op_a >> op_b[4:0];
            5'd6:    alu_res = op_a - op_b;
            5'd7:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            5'd10:   alu_res = op_b;
            5'd13:   alu_res = {31'd0, op_a < op_b};
            5'd15:   alu_res = $signed(op_a) >>> op_b[4:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        load_use = mem_read_q && (write_reg_q != 5'd0) &&
                   ((d_read_reg1 && (d_reg1_addr == write_reg_q)) ||
                    (d_read_reg2 && (d_reg2_addr == write_reg_q)));
        stall_out = load_use | stall_in;
    end

    // Downstream hold beats the bubble; a bubble only clears the enables.
    always_comb begin
        result_d     = result_q;
        store_data_d = store_data_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        if (!stall_in) begin
            if (load_use) begin
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end else begin
                result_d     = alu_res;
                store_data_d = rs2_fwd;
                write_reg_d  = d_write_reg;
                reg_write_d  = d_reg_write;
                mem_read_d   = d_mem_read;
                mem_write_d  = d_mem_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q     <= '0;
            store_data_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            result_q     <= result_d;
            store_data_q <= store_data_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign e_result     = result_q;
    assign e_store_data = store_data_q;
    assign e_write_reg  = write_reg_q;
    assign e_reg_write  = reg_write_q;
    assign e_mem_read   = mem_read_q;
    assign e_mem_write  = mem_write_q;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the in-order RV32I integer pipeline, directly downstream of the decode register stage. It owns the 32×32 integer register file, reads and forwards operands, and evaluates the ALU on the decoded `ctl` code. It registers the result into the EX/MEM pipeline register and detects load-use hazards, stalling decode and fetch by one cycle.

## Interface
Parameters:
- none; XLEN fixed at 32, 32 architectural registers.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `d_imm` in 32: decoded immediate.
- `d_ctl` in 5: ALU control code.
- `d_src_imm` in 1: operand B select; 1 = `d_imm`, 0 = rs2.
- `d_src_pc` in 1: operand A select; 1 = `d_pc`, 0 = rs1.
- `d_read_reg1` in 1: rs1 is a true source.
- `d_read_reg2` in 1: rs2 is a true source.
- `d_reg1_addr` in 5: rs1 index.
- `d_reg2_addr` in 5: rs2 index.
- `d_write_reg` in 5: rd index.
- `d_reg_write` in 1: instruction writes rd.
- `d_mem_read` in 1: load.
- `d_mem_write` in 1: store.
- `d_pc` in 32: instruction PC.
- `stall_in` in 1: downstream (memory) stall; hold EX/MEM.
- `wb_en` in 1: writeback write enable.
- `wb_addr` in 5: writeback rd.
- `wb_data` in 32: writeback value.
- `e_result` out 32: ALU result / memory address.
- `e_store_data` out 32: forwarded rs2 for stores.
- `e_write_reg` out 5: rd.
- `e_reg_write` out 1: rd write enable.
- `e_mem_read` out 1: load.
- `e_mem_write` out 1: store.
- `stall_out` out 1: combinational; hold decode and fetch this cycle.

## Operation
- **Register file**
  - Written at posedge when `wb_en` and `wb_addr != 0`.
  - Reads are combinational.
  - x0 always reads 0.
  - Reset clears all 32 entries.
- **Operand forwarding**, per source, in priority order:
  1. Address 0 → 0.
  2. EX/MEM match: `e_reg_write & ~e_mem_read & e_write_reg == addr` → `e_result`.
  3. WB match: `wb_en & wb_addr == addr` → `wb_data`.
  4. Otherwise the array value.
- **Operands**
  - A = `d_src_pc ? d_pc : rs1f`.
  - B = `d_src_imm ? d_imm : rs2f`.
  - Store data = `rs2f`.
- **ALU on `d_ctl`** (all arithmetic mod 2^32):
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB.
  - 4 SLL, 5 SRL, 15 SRA; shift amount = B[4:0].
  - 7 SLT (signed) → 0/1; 13 SLTU (unsigned) → 0/1.
  - 10 pass B (LUI).
  - Every other code, including 31 → 0.
- **Load-use hazard**
  - `lu = e_mem_read & e_write_reg != 0 & ((d_read_reg1 & d_reg1_addr == e_write_reg) | (d_read_reg2 & d_reg2_addr == e_write_reg))`.
  - `stall_out = lu | stall_in`.
- **Register update**
  - If `stall_in`: EX/MEM holds its values.
  - Else if `lu`: a bubble is inserted. `e_reg_write`, `e_mem_read` and `e_mem_write` go to 0; the other fields are don't-care but hold.
  - Else: EX/MEM captures the ALU result and the `d_*` control fields.
  - Regfile writes occur regardless of stalls.

## Timing
- **Reset:** every `e_*` output is 0, `stall_out` is `stall_in`, regfile is all 0. `rst` mid-operation discards any in-flight instruction at that edge.
- **Latency:** one cycle from `d_*` to `e_*`. The ALU path is combinational within the cycle.
- **Load-use:** exactly one bubble. Decode holds its outputs because `stall_out` is high. On the next cycle the load sits in MEM, `e_mem_read` is 0 and the hazard clears. The load value reaches execute via the WB bypass or the regfile, which requires MEM/WB to deliver it on `wb_*` by that cycle.
- **Simultaneous WB and EX/MEM match:** EX/MEM wins, being the younger instruction.
- **Same-cycle WB write and read:** the read returns `wb_data`.
- **`stall_in` and `lu` together:** hold wins; no bubble is inserted this cycle.

## Test plan
- **Reset then ALU:** `rst`; then ADDI x1 = 5 via `wb`, then `ctl`=2, rs1=x1, imm=−7 → `e_result` = 0xFFFFFFFE one cycle later. All `e_*` are 0 during reset.
- **Back-to-back forward:** x1 = 3, x2 = 4 via WB.
  - ADD x3 = x1 + x2, then SUB x4 = x3 − x1 on consecutive cycles → 7, then 4, with no stall.
- **Shifts/compares:**
  - A = 0x80000000, B = 4: SRL → 0x08000000, SRA → 0xF8000000.
  - A = −1, B = 1: SLT → 1, SLTU → 0.
  - `ctl`=31 → 0.
- **Load-use:** LW x5 then ADD x6 = x5 + x0.
  - `stall_out` is 1 for exactly one cycle and the bubble shows `e_reg_write`=0.
  - With `wb_data` = 0x1234 for x5, the ADD gives `e_result` = 0x1234.
- **x0 handling:** WB writes 0xFFFF to x0; EX/MEM holds rd = x0 with result 9; reading x0 → 0. A load to x0 followed by a use of x0 → no stall.
- **`stall_in`:** asserted for 3 cycles mid-stream → `e_*` held unchanged and `stall_out` = 1 throughout; a WB write during the stall is later visible in the regfile.
